// File: rtl/ov7670_config_seq.sv
// Steps through a 16-bit camera configuration ROM and issues one SCCB register access per entry.
// Define OV7670_CFG_READBACK_EN to turn FE_xx entries into SCCB reads; without it they are skipped.
module ov7670_config_seq #(
   parameter int unsigned DELAY_CYCLES = 250000,
   parameter logic [7:0]  ROM_LAST     = 8'd255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_addr,
   output logic        rom_clk_en,
   input  logic [15:0] rom_dout,
   output logic        sccb_start,
   input  logic        sccb_ready,
   output logic        sccb_rd,
   output logic [7:0]  sccb_reg,
   output logic [7:0]  sccb_wdata,
   input  logic        sccb_done,
   input  logic [7:0]  sccb_rdata,
   output logic [7:0]  last_rdata,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state_dbg
);

   // SCCB handshake: sccb_start is held with sccb_rd/sccb_reg/sccb_wdata stable
   // until a clock edge sees sccb_ready=1; that edge is the transfer.
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, DECODE, SEND, WAIT, DELAY, DONE} state_t;

   localparam logic [31:0] DELAY_LOAD = (DELAY_CYCLES > 0) ? DELAY_CYCLES - 1 : 32'd0;

   state_t      state;
   logic [15:0] entry;
   logic [31:0] delay_cnt;
   logic        at_last;
   logic        advance;

   assign state_dbg = state;
   assign at_last   = (rom_addr == ROM_LAST);

`ifdef OV7670_CFG_READBACK_EN
   logic [7:0] rdata_q;
   assign last_rdata = rdata_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^sccb_rdata;
   assign last_rdata   = 8'd0;
`endif

   // Every way of finishing an entry funnels through one address-advance path.
   always_comb begin
      advance = 1'b0;
      case (state)
         WAIT:    advance = sccb_done;
         DELAY:   advance = (delay_cnt == 32'd0);
`ifndef OV7670_CFG_READBACK_EN
         DECODE:  advance = (entry[15:8] == 8'hFE);
`endif
         default: advance = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rom_addr   <= 8'd0;
         rom_clk_en <= 1'b0;
         entry      <= 16'd0;
         delay_cnt  <= 32'd0;
         sccb_start <= 1'b0;
         sccb_rd    <= 1'b0;
         sccb_reg   <= 8'd0;
         sccb_wdata <= 8'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef OV7670_CFG_READBACK_EN
         rdata_q    <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  rom_addr   <= 8'd0;
                  rom_clk_en <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               rom_clk_en <= 1'b0;
               state      <= LATCH;
            end
            LATCH: begin
               entry <= rom_dout;
               state <= DECODE;
            end
            DECODE: begin
               if (entry == 16'hFFFF) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (entry == 16'hFFF0) begin
                  delay_cnt <= DELAY_LOAD;
                  state     <= DELAY;
               end else if (entry[15:8] == 8'hFE) begin
`ifdef OV7670_CFG_READBACK_EN
                  sccb_start <= 1'b1;
                  sccb_rd    <= 1'b1;
                  sccb_reg   <= entry[7:0];
                  sccb_wdata <= 8'd0;
                  state      <= SEND;
`endif
               end else begin
                  sccb_start <= 1'b1;
                  sccb_rd    <= 1'b0;
                  sccb_reg   <= entry[15:8];
                  sccb_wdata <= entry[7:0];
                  state      <= SEND;
               end
            end
            SEND: begin
               if (sccb_ready) begin
                  sccb_start <= 1'b0;
                  state      <= WAIT;
               end
            end
            WAIT: begin
`ifdef OV7670_CFG_READBACK_EN
               if (sccb_done && sccb_rd) rdata_q <= sccb_rdata;
`endif
            end
            DELAY: begin
               if (delay_cnt != 32'd0) delay_cnt <= delay_cnt - 32'd1;
            end
            default: state <= IDLE;
         endcase

         if (advance) begin
            if (at_last) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end else begin
               rom_addr   <= rom_addr + 8'd1;
               rom_clk_en <= 1'b1;
               state      <= FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: ROM and SCCB slave models, directed cases, then randomized ROM images
// checked against a table-walking reference of the configuration sequence.
module tb_ov7670_config_seq;

   localparam int DLY  = 5;
   localparam int LAST = 2;
`ifdef OV7670_CFG_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  rom_addr;
   logic        rom_clk_en;
   logic [15:0] rom_dout = 16'd0;
   logic        sccb_start;
   logic        sccb_ready;
   logic        sccb_rd;
   logic [7:0]  sccb_reg;
   logic [7:0]  sccb_wdata;
   logic        sccb_done = 1'b0;
   logic [7:0]  sccb_rdata = 8'd0;
   logic [7:0]  last_rdata;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   ov7670_config_seq #(.DELAY_CYCLES(DLY), .ROM_LAST(8'(LAST))) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_addr(rom_addr), .rom_clk_en(rom_clk_en), .rom_dout(rom_dout),
      .sccb_start(sccb_start), .sccb_ready(sccb_ready), .sccb_rd(sccb_rd),
      .sccb_reg(sccb_reg), .sccb_wdata(sccb_wdata), .sccb_done(sccb_done),
      .sccb_rdata(sccb_rdata), .last_rdata(last_rdata), .busy(busy), .done(done),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // ROM model: data appears the cycle after the enable
   logic [15:0] rom [0:255];
   always @(posedge clk) if (rom_clk_en) rom_dout <= rom[rom_addr];

   // SCCB slave model: records each accepted transfer, pulses done lat cycles later
   int          done_lat  = 3;
   logic [7:0]  rdata_val = 8'd0;
   int          pend      = 0;
   logic [16:0] obs_q[$];
   logic [16:0] exp_q[$];
   logic [7:0]  exp_last;

   always @(posedge clk) begin
      sccb_done  <= 1'b0;
      sccb_rdata <= 8'($urandom);
      if (sccb_start && sccb_ready) begin
         obs_q.push_back({sccb_rd, sccb_reg, sccb_rd ? 8'h00 : sccb_wdata});
         pend <= done_lat;
      end else if (pend == 1) begin
         sccb_done  <= 1'b1;
         sccb_rdata <= rdata_val;
         pend       <= 0;
      end else if (pend > 1) begin
         pend <= pend - 1;
      end
   end

   // scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rom_addr"}, rom_addr, 0);
      chk({tag, "_rom_clk_en"}, rom_clk_en, 0);
      chk({tag, "_sccb_start"}, sccb_start, 0);
      chk({tag, "_sccb_rd"}, sccb_rd, 0);
      chk({tag, "_sccb_reg"}, sccb_reg, 0);
      chk({tag, "_sccb_wdata"}, sccb_wdata, 0);
      chk({tag, "_last_rdata"}, last_rdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_state_idle"}, state_dbg, 0);
   endtask

   // Reference: walk the ROM image entry by entry and predict transfers, fetches,
   // cycles spent in delay and total busy time (3 cycles per entry plus send/wait or delay).
   task automatic model(input int lat, output int e_busy, output int e_fetch,
                        output int e_delay, output bit e_read);
      logic [15:0] e;
      exp_q.delete();
      e_busy = 0; e_fetch = 0; e_delay = 0; e_read = 1'b0;
      for (int a = 0; a <= LAST; a++) begin
         e = rom[a];
         e_fetch++;
         e_busy += 3;
         if (e == 16'hFFFF) break;
         if (e == 16'hFFF0) begin
            e_busy  += DLY;
            e_delay += DLY;
         end else if (e[15:8] == 8'hFE) begin
            if (READBACK) begin
               exp_q.push_back({1'b1, e[7:0], 8'h00});
               e_busy += lat + 2;
               e_read = 1'b1;
            end
         end else begin
            exp_q.push_back({1'b0, e[15:8], e[7:0]});
            e_busy += lat + 2;
         end
      end
   endtask

   // driver: pulse start, optionally re-pulse it while busy, measure until done
   task automatic run_seq(input int lat, input bit poke, output int b, output int f, output int d);
      int poke_at;
      poke_at  = $urandom_range(1, 8);
      done_lat = lat;
      obs_q.delete();
      b = 0; f = 0; d = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         b += int'(busy);
         f += int'(rom_clk_en);
         d += int'(state_dbg == 3'd6);
         start = (poke && c == poke_at && busy);
         @(negedge clk);
      end
      start = 1'b0;
      chk("run_reached_done", done, 1);
   endtask

   task automatic run_and_check(input string tag, input int lat, input bit poke);
      int eb, ef, ed, b, f, d;
      bit er;
      model(lat, eb, ef, ed, er);
      run_seq(lat, poke, b, f, d);
      if (er) exp_last = rdata_val;
      chk({tag, "_busy_cycles"}, b, eb);
      chk({tag, "_fetches"}, f, ef);
      chk({tag, "_delay_cycles"}, d, ed);
      chk({tag, "_txn_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk({tag, "_txn"}, obs_q[i], exp_q[i]);
      chk({tag, "_last_rdata"}, last_rdata, exp_last);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic load3(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
      rom[0] = e0; rom[1] = e1; rom[2] = e2;
   endtask

   initial begin
      int kind;
      rst_n = 1'b0; start = 1'b0; sccb_ready = 1'b1; exp_last = 8'd0;
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // single write then end marker
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
      run_and_check("write1", 3, 1'b0);
      chk("write1_txn", (obs_q.size() > 0) ? {15'd0, obs_q[0]} : 32'hDEAD, {15'd0, 1'b0, 8'h12, 8'h80});
      chk("write1_done", done, 1);

      // delay entry
      load3(16'hFFF0, 16'hFFFF, 16'hFFFF);
      run_and_check("delay", 3, 1'b0);

      // reset while waiting for sccb_done; the late done must be ignored
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
      done_lat = 8;
      obs_q.delete();
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int c = 0; c < 40 && obs_q.size() == 0; c++) @(negedge clk);
      chk("rstwait_accepted", obs_q.size(), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      exp_last = 8'd0;
      chk_reset("rstwait");
      repeat (12) @(negedge clk);
      chk("rstwait_pend_drained", pend, 0);
      chk("rstwait_no_new_txn", obs_q.size(), 1);
      chk_reset("rstwait_late");

      // readback entry
      load3(16'hFE1A, 16'hFFFF, 16'hFFFF);
      rdata_val = 8'h76;
      run_and_check("read", 3, 1'b0);
      chk("read_last_rdata", last_rdata, READBACK ? 32'h76 : 32'h0);

      // ready held low for 10 cycles in SEND
      load3(16'h1280, 16'hFFFF, 16'hFFFF);
      sccb_ready = 1'b0;
      done_lat = 3;
      obs_q.delete();
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int c = 0; c < 20 && !sccb_start; c++) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         chk("stall_start", sccb_start, 1);
         chk("stall_fields", {sccb_rd, sccb_reg, sccb_wdata}, {1'b0, 8'h12, 8'h80});
         @(negedge clk);
      end
      sccb_ready = 1'b1;
      for (int c = 0; c < 40 && !done; c++) @(negedge clk);
      chk("stall_done", done, 1);
      chk("stall_single_accept", obs_q.size(), 1);

      // no end marker: stops after ROM_LAST, and restarts from address 0
      load3(16'h1111, 16'h2222, 16'h3333);
      run_and_check("romlast_a", 2, 1'b0);
      run_and_check("romlast_b", 2, 1'b0);

      // randomized ROM images
      for (int it = 0; it < 25; it++) begin
         for (int a = 0; a <= LAST; a++) begin
            kind = $urandom_range(0, 5);
            case (kind)
               0, 1, 2: rom[a] = {8'($urandom_range(0, 8'hFD)), 8'($urandom)};
               3:       rom[a] = {8'hFE, 8'($urandom)};
               4:       rom[a] = 16'hFFF0;
               default: rom[a] = 16'hFFFF;
            endcase
         end
         rdata_val = 8'($urandom);
         run_and_check("rand", $urandom_range(1, 4), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
